// File: rtl/npc_trap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : npc_trap_pkg                                                 |
// | Description: SYSTEM instruction encodings, event type enum, event record  |
// |              and the retire-word decoder shared by the trap monitor.      |
// | Revision   : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package npc_trap_pkg;

  localparam logic [31:0] C_INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] C_INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] C_INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] C_INST_WFI    = 32'h1050_0073;

  localparam int C_NUM_TYPES = 4;
  localparam int C_REC_XLEN  = 32;

  typedef enum logic [1:0] {
    EVT_ECALL  = 2'd0,
    EVT_EBREAK = 2'd1,
    EVT_MRET   = 2'd2,
    EVT_WFI    = 2'd3
  } evt_type_e;

  // Record layout for the default 32-bit core; the top packs the same
  // fields in the same order for any XLEN.
  typedef struct packed {
    evt_type_e              typ;
    logic [C_REC_XLEN-1:0]  pc;
    logic [C_REC_XLEN-1:0]  a0;
  } evt_rec_t;

  typedef struct packed {
    logic      hit;
    evt_type_e typ;
  } evt_dec_t;

  // Exact 32-bit match against the four tracked SYSTEM instructions.
  function automatic evt_dec_t evt_decode(input logic [31:0] inst);
    evt_dec_t d;
    d.hit = 1'b1;
    d.typ = EVT_ECALL;
    case (inst)
      C_INST_ECALL:  d.typ = EVT_ECALL;
      C_INST_EBREAK: d.typ = EVT_EBREAK;
      C_INST_MRET:   d.typ = EVT_MRET;
      C_INST_WFI:    d.typ = EVT_WFI;
      default:       d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_evt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : trap_evt_fifo                                                |
// | Description: DEPTH-entry event FIFO, synchronous write, head read from    |
// |              registered storage. Pointers carry an extra wrap bit.        |
// | Revision   : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module trap_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];

  logic w_full, w_empty, w_wr_en, w_rd_en;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write while full is allowed only when the head leaves in the same cycle.
  assign w_wr_en = push_i && (!w_full || pop_i);
  assign w_rd_en = pop_i && !w_empty;

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (w_rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = w_empty;
  assign full_o  = w_full;

endmodule
`default_nettype wire

// File: rtl/trap_event_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : trap_event_monitor                                          |
// | Description: Classifies retired SYSTEM instructions, queues event records |
// |              {type, pc, a0}, keeps saturating per-type and drop counters, |
// |              sticky overflow, and a sticky EBREAK halt request.           |
// | Revision   : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module trap_event_monitor
  import npc_trap_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         DEPTH    = 4,
  parameter logic [3:0] EVT_MASK = 4'b1111,
  parameter int         CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ret_valid,
  input  logic [31:0]        ret_inst,
  input  logic [XLEN-1:0]    ret_pc,
  input  logic [XLEN-1:0]    ret_a0,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_type,
  output logic [XLEN-1:0]    evt_pc,
  output logic [XLEN-1:0]    evt_a0,
  output logic [4*CNT_W-1:0] cnt_flat,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               ovf,
  output logic               halt_req,
  output logic [XLEN-1:0]    halt_code
);

  localparam int REC_W = 2 + 2*XLEN;

  evt_dec_t         w_dec;
  logic             w_hit, w_pop, w_drop, w_empty, w_full, w_ebreak;
  logic [REC_W-1:0] w_wdata, w_head;

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;
  logic             halt_req_q, halt_req_d;
  logic [XLEN-1:0]  halt_code_q, halt_code_d;

  assign w_dec    = evt_decode(ret_inst);
  assign w_hit    = ret_valid && w_dec.hit && EVT_MASK[w_dec.typ];
  assign w_pop    = evt_valid && evt_ready;
  assign w_drop   = w_hit && w_full && !w_pop;
  assign w_ebreak = w_hit && (w_dec.typ == EVT_EBREAK);
  assign w_wdata  = {w_dec.typ, ret_pc, ret_a0};

  trap_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_hit),
    .pop_i   (w_pop),
    .wdata_i (w_wdata),
    .rdata_o (w_head),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  // Head fields are forced to zero while nothing is queued.
  assign evt_valid = !w_empty;
  assign evt_type  = w_empty ? 2'd0       : w_head[REC_W-1 -: 2];
  assign evt_pc    = w_empty ? '0         : w_head[2*XLEN-1 -: XLEN];
  assign evt_a0    = w_empty ? '0         : w_head[XLEN-1:0];

  // One saturating counter per event type, counting even when the record drops.
  for (genvar t = 0; t < C_NUM_TYPES; t++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Increment on a matched retire of this type unless already saturated.
    always_comb begin
      cnt_d = cnt_q;
      if (w_hit && (w_dec.typ == 2'(t)) && (cnt_q != '1))
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign cnt_flat[t*CNT_W +: CNT_W] = cnt_q;
  end

  // Drop accounting, sticky overflow, and first-EBREAK halt capture.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    ovf_d       = ovf_q;
    halt_req_d  = halt_req_q;
    halt_code_d = halt_code_q;
    if (w_drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    if (w_ebreak) begin
      halt_req_d = 1'b1;
      if (!halt_req_q) halt_code_d = ret_a0;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      halt_req_q  <= 1'b0;
      halt_code_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
      halt_req_q  <= halt_req_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign ovf       = ovf_q;
  assign halt_req  = halt_req_q;
  assign halt_code = halt_code_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_event_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_trap_event_monitor                                       |
// | Description: Directed self-checking bench for trap_event_monitor.        |
// | Revision   : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_trap_event_monitor;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] WFI    = 32'h1050_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ret_valid;
  logic [31:0] ret_inst, ret_pc, ret_a0;
  logic        evt_ready;

  // Main instance: DEPTH 4, CNT_W 16, all types enabled.
  logic        d_valid, d_ovf, d_halt;
  logic [1:0]  d_type;
  logic [31:0] d_pc, d_a0, d_code;
  logic [63:0] d_cnt;
  logic [15:0] d_drop;

  // Masked instance: WFI disabled.
  logic        m_valid, m_ovf, m_halt;
  logic [1:0]  m_type;
  logic [31:0] m_pc, m_a0, m_code;
  logic [63:0] m_cnt;
  logic [15:0] m_drop;

  // Small instance for saturation: DEPTH 2, CNT_W 2.
  logic        s_valid, s_ovf, s_halt;
  logic [1:0]  s_type;
  logic [31:0] s_pc, s_a0, s_code;
  logic [7:0]  s_cnt;
  logic [1:0]  s_drop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  trap_event_monitor #(.XLEN(32), .DEPTH(4), .EVT_MASK(4'b1111), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_inst(ret_inst),
    .ret_pc(ret_pc), .ret_a0(ret_a0), .evt_valid(d_valid), .evt_ready(evt_ready),
    .evt_type(d_type), .evt_pc(d_pc), .evt_a0(d_a0), .cnt_flat(d_cnt),
    .drop_cnt(d_drop), .ovf(d_ovf), .halt_req(d_halt), .halt_code(d_code));

  trap_event_monitor #(.XLEN(32), .DEPTH(4), .EVT_MASK(4'b0111), .CNT_W(16)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_inst(ret_inst),
    .ret_pc(ret_pc), .ret_a0(ret_a0), .evt_valid(m_valid), .evt_ready(evt_ready),
    .evt_type(m_type), .evt_pc(m_pc), .evt_a0(m_a0), .cnt_flat(m_cnt),
    .drop_cnt(m_drop), .ovf(m_ovf), .halt_req(m_halt), .halt_code(m_code));

  trap_event_monitor #(.XLEN(32), .DEPTH(2), .EVT_MASK(4'b1111), .CNT_W(2)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_inst(ret_inst),
    .ret_pc(ret_pc), .ret_a0(ret_a0), .evt_valid(s_valid), .evt_ready(evt_ready),
    .evt_type(s_type), .evt_pc(s_pc), .evt_a0(s_a0), .cnt_flat(s_cnt),
    .drop_cnt(s_drop), .ovf(s_ovf), .halt_req(s_halt), .halt_code(s_code));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one retire for a single clock edge; outputs are then sampled at the negedge.
  task automatic retire(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a0);
    ret_valid = 1'b1;
    ret_inst  = inst;
    ret_pc    = pc;
    ret_a0    = a0;
    @(negedge clk);
    ret_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    ret_valid = 1'b0;
    ret_inst  = 32'h0;
    ret_pc    = 32'h0;
    ret_a0    = 32'h0;
    evt_ready = 1'b0;
    idle(2);

    // Reset state.
    chk("rst_valid", {63'd0, d_valid}, 64'd0);
    chk("rst_head",  {30'd0, d_type, d_pc}, 64'd0);
    chk("rst_cnt",   d_cnt, 64'd0);
    chk("rst_status", {d_drop, d_ovf, d_halt, d_code}, 64'd0);
    rst_n = 1'b1;
    idle(1);

    // 1. Single ECALL, head appears one cycle later.
    evt_ready = 1'b1;
    retire(ECALL, 32'h8000_0010, 32'h11);
    chk("t1_valid", {63'd0, d_valid}, 64'd1);
    chk("t1_head",  {30'd0, d_type, d_pc}, {30'd0, 2'd0, 32'h8000_0010});
    chk("t1_a0",    {32'd0, d_a0}, 64'h11);
    chk("t1_cnt0",  {48'd0, d_cnt[15:0]}, 64'd1);
    idle(1);
    chk("t1_popped", {63'd0, d_valid}, 64'd0);

    // 2. Six MRETs with the consumer stalled: 4 queued, 2 dropped.
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) retire(MRET, 32'h100 + 32'(4*i), 32'h50 + 32'(i));
    chk("t2_drop",  {48'd0, d_drop}, 64'd2);
    chk("t2_ovf",   {63'd0, d_ovf}, 64'd1);
    chk("t2_cnt2",  {48'd0, d_cnt[47:32]}, 64'd6);
    idle(1);
    chk("t2_stable", {30'd0, d_type, d_pc}, {30'd0, 2'd2, 32'h100});
    chk("t2_sat_cnt",  {56'd0, s_cnt}, {56'd0, 2'd0, 2'd3, 2'd0, 2'd1});
    chk("t2_sat_drop", {62'd0, s_drop}, 64'd3);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain", {d_valid, 29'd0, d_type, d_pc, d_a0[7:0]},
          {1'b1, 29'd0, 2'd2, 32'h100 + 32'(4*i), 8'h50 + 8'(i)});
      @(negedge clk);
    end
    chk("t2_empty", {63'd0, d_valid}, 64'd0);

    // 3. Full FIFO with push and pop together: nothing dropped, occupancy stays 4.
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) retire(MRET, 32'h200 + 32'(4*i), 32'h0);
    evt_ready = 1'b1;
    retire(MRET, 32'h210, 32'h0);
    chk("t3_nodrop", {47'd0, d_ovf, d_drop}, 64'd0);
    chk("t3_head",   {32'd0, d_pc}, 64'h204);
    evt_ready = 1'b0;
    retire(MRET, 32'h214, 32'h0);
    chk("t3_still_full", {47'd0, d_ovf, d_drop}, {47'd0, 1'b1, 16'd1});
    chk("t3_cnt2", {48'd0, d_cnt[47:32]}, 64'd6);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", {31'd0, d_valid, d_pc}, {31'd0, 1'b1, 32'h204 + 32'(4*i)});
      @(negedge clk);
    end
    chk("t3_empty", {63'd0, d_valid}, 64'd0);

    // 4. EBREAK a0=0 then EBREAK a0=7: halt from first, code stays 0.
    chk("t4_pre_halt", {63'd0, d_halt}, 64'd0);
    retire(EBREAK, 32'h300, 32'h0);
    chk("t4_halt1", {31'd0, d_halt, d_code}, {31'd0, 1'b1, 32'h0});
    chk("t4_head1", {30'd0, d_type, d_pc}, {30'd0, 2'd1, 32'h300});
    retire(EBREAK, 32'h304, 32'h7);
    chk("t4_halt2", {31'd0, d_halt, d_code}, {31'd0, 1'b1, 32'h0});
    chk("t4_cnt1", {48'd0, d_cnt[31:16]}, 64'd2);
    idle(1);

    // 5. WFI masked on the second instance; non-matching words do nothing.
    retire(WFI, 32'h400, 32'h0);
    chk("t5_wfi_on",  {30'd0, d_type, d_valid, d_pc[30:0]}, {30'd0, 2'd3, 1'b1, 31'h400});
    chk("t5_wfi_off", {63'd0, m_valid}, 64'd0);
    chk("t5_m_cnt",   m_cnt, 64'h0000_0006_0002_0000);
    retire(32'h0000_0013, 32'h404, 32'h0);
    chk("t5_nop", {63'd0, d_valid}, 64'd0);
    retire(32'h0020_0073, 32'h408, 32'h0);
    chk("t5_near", {63'd0, d_valid}, 64'd0);
    ret_inst = ECALL;
    idle(1);
    chk("t5_novalid", {63'd0, d_valid}, 64'd0);
    chk("t5_cnt", d_cnt, 64'h0001_0006_0002_0000);

    // 6. Asynchronous reset while three records are queued.
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) retire(ECALL, 32'h500 + 32'(4*i), 32'h0);
    chk("t6_queued", {47'd0, d_valid, d_cnt[15:0]}, {47'd0, 1'b1, 16'd3});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {63'd0, d_valid}, 64'd0);
    chk("t6_async_cnt",   d_cnt, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("t6_after", {46'd0, d_valid, d_ovf, d_halt, d_drop, d_pc[14:0]}, 64'd0);
    chk("t6_code",  {32'd0, d_code}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
